// File: rtl/seg7_scan_pkg.sv
// Shared constants, slot state type and leading-zero helper for the
// multiplexed 7-segment scan stage.
package seg7_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

    // GUARD: digit enables off at slot start; SHOW: active digit driven.
    typedef enum logic {
        GUARD,
        SHOW
    } slot_state_t;

    // True when digit idx (1..3) and every digit to its left are zero.
    // Digit 0 is never a leading zero, so a zero value still shows "0".
    function automatic logic is_leading_zero(input logic [VALUE_W-1:0] value,
                                             input logic [1:0]         idx);
        case (idx)
            2'd1:    return value[15:4]  == '0;
            2'd2:    return value[15:8]  == '0;
            2'd3:    return value[15:12] == '0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg7.sv
// Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}.
module seg7 (
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Pure lookup of the glyph for one hex digit.
    always_comb begin
        case (digit)
            4'h0:    segments = 7'h3F;
            4'h1:    segments = 7'h06;
            4'h2:    segments = 7'h5B;
            4'h3:    segments = 7'h4F;
            4'h4:    segments = 7'h66;
            4'h5:    segments = 7'h6D;
            4'h6:    segments = 7'h7D;
            4'h7:    segments = 7'h07;
            4'h8:    segments = 7'h7F;
            4'h9:    segments = 7'h6F;
            4'hA:    segments = 7'h77;
            4'hB:    segments = 7'h7C;
            4'hC:    segments = 7'h39;
            4'hD:    segments = 7'h5E;
            4'hE:    segments = 7'h79;
            default: segments = 7'h71;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// 4-digit multiplexed common-cathode display driver. Values enter through a
// one-deep valid/ready buffer and are committed only at frame wrap so a frame
// never mixes two values. Each slot starts with a blanked guard interval.
module seg7_scan_mux
    import seg7_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 10_000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int                CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  GUARD_LIM   = CNT_W'(GUARD_CYCLES);
    localparam slot_state_t       SLOT_START  = (GUARD_CYCLES > 0) ? GUARD : SHOW;

    logic [CNT_W-1:0]      slot_cnt;
    logic [1:0]            digit_idx;
    slot_state_t           state_q, state_d;

    logic [VALUE_W-1:0]    disp_reg;
    logic [VALUE_W-1:0]    pend_reg;
    logic                  pend_full, pend_full_d;

    logic                  slot_wrap, frame_wrap, xfer;
    logic [NIBBLE_W-1:0]   sel_nibble;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] en_d;

    assign slot_wrap  = (slot_cnt == CNT_MAX);
    assign frame_wrap = slot_wrap && (digit_idx == 2'd3);
    assign xfer       = value_valid && value_ready;
    assign sel_nibble = disp_reg[digit_idx*NIBBLE_W +: NIBBLE_W];

    seg7 u_dec (
        .digit    (sel_nibble),
        .segments (dec_seg)
    );

    // Slot timebase: slot counter, digit index and slot FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            state_q   <= SLOT_START;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= digit_idx + 2'd1;
            end
            state_q <= state_d;
        end
    end

    // Next slot state and next-cycle pin values derived from the current slot.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d     = state_q;
        seg_d       = '0;
        dp_d        = 1'b0;
        en_d        = '0;
        pend_full_d = pend_full;

        if (slot_wrap) begin
            state_d = SLOT_START;
        end else if ((slot_cnt + 1'b1) >= GUARD_LIM) begin
            state_d = SHOW;
        end

        if (state_q == SHOW) begin
            en_d  = 4'b0001 << digit_idx;
            dp_d  = dp_mask[digit_idx];
            seg_d = (blank_lz && is_leading_zero(disp_reg, digit_idx)) ? '0 : dec_seg;
        end

        // A transfer can only occur while nothing is pending, so it never
        // collides with a commit of the pending value.
        if (xfer) begin
            pend_full_d = 1'b1;
        end else if (frame_wrap) begin
            pend_full_d = 1'b0;
        end
    end

    // Handshake buffer state and frame-boundary commit into the display value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_full   <= 1'b0;
            value_ready <= 1'b0;
            disp_reg    <= '0;
        end else begin
            if (frame_wrap && pend_full) begin
                disp_reg <= pend_reg;
            end
            pend_full   <= pend_full_d;
            value_ready <= !pend_full_d;
        end
    end

    // Pending data register; captured on each accepted transfer.
    always_ff @(posedge clk) begin
        // NOTE: no reset on pure data storage; pend_full says whether it is valid.
        if (xfer) begin
            pend_reg <= value_in;
        end
    end

    // Registered display pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segments <= '0;
            dp       <= 1'b0;
            digit_en <= '0;
        end else begin
            segments <= seg_d;
            dp       <= dp_d;
            digit_en <= en_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with SCAN_DIV=8, GUARD_CYCLES=2.
// A frame-position reference model checks every cycle; table vectors and
// hand sequences cover the multi-cycle corner cases.
module tb_seg7_scan_mux;

    localparam int SCAN_DIV     = 8;
    localparam int GUARD_CYCLES = 2;
    localparam int FRAME        = SCAN_DIV * 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  digit_en;

    seg7_scan_mux #(
        .SCAN_DIV     (SCAN_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .blank_lz    (blank_lz),
        .dp_mask     (dp_mask),
        .segments    (segments),
        .dp          (dp),
        .digit_en    (digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph reference, {g,f,e,d,c,b,a}
    logic [6:0] glyph [16];
    initial begin
        glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
        glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
        glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
        glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: position within the frame plus displayed/pending values.
    int          m_pos;
    logic [15:0] m_disp, m_pend;
    bit          m_pend_full, m_ready, m_last_xfer;

    // Advance one clock; expected pins derive from the pre-edge model position.
    task automatic step();
        logic [3:0] e_en;
        logic [6:0] e_seg;
        logic       e_dp;
        int         slot, d;
        logic [15:0] upper;
        e_en = '0; e_seg = '0; e_dp = 1'b0;
        m_last_xfer = 0;
        if (!rst_n) begin
            m_pos = 0; m_disp = '0; m_pend_full = 0; m_ready = 0;
        end else begin
            slot = m_pos % SCAN_DIV;
            d    = m_pos / SCAN_DIV;
            if (slot >= GUARD_CYCLES) begin
                e_en  = 4'(1 << d);
                e_dp  = dp_mask[d];
                upper = m_disp >> (4 * d);
                if (blank_lz && d > 0 && upper == 16'h0) e_seg = '0;
                else e_seg = glyph[upper[3:0]];
            end
            m_last_xfer = value_valid && m_ready;
            if (m_pos == FRAME - 1 && m_pend_full) begin
                m_disp      = m_pend;
                m_pend_full = 0;
            end
            if (m_last_xfer) begin
                m_pend      = value_in;
                m_pend_full = 1;
            end
            m_pos   = (m_pos + 1) % FRAME;
            m_ready = !m_pend_full;
        end
        @(posedge clk);
        #1;
        check("digit_en", digit_en, e_en);
        check("segments", segments, e_seg);
        check("dp", dp, e_dp);
        check("value_ready", value_ready, m_ready);
    endtask

    task automatic send(input logic [15:0] v);
        bit got = 0;
        value_valid = 1'b1;
        value_in    = v;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = m_last_xfer;
        end
        value_valid = 1'b0;
        check("send_accepted", got, 1);
    endtask

    task automatic wait_commit();
        for (int i = 0; i < 100 && !value_ready; i++) step();
        check("commit_ready", value_ready, 1);
    endtask

    // Record the last glyph/dp seen on each digit over n cycles.
    task automatic capture(input int n, output logic [3:0][6:0] seg,
                           output logic [3:0] dpv, output logic [3:0] seen);
        seg = '0; dpv = '0; seen = '0;
        repeat (n) begin
            step();
            for (int d = 0; d < 4; d++) begin
                if (digit_en == 4'(1 << d)) begin
                    seg[d]  = segments;
                    dpv[d]  = dp;
                    seen[d] = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        logic [15:0]     value;
        logic            blank;
        logic [3:0]      dpm;
        logic [3:0][6:0] seg;   // expected glyph, index = digit
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        logic [3:0][6:0] cs;
        logic [3:0]      cdp, cseen;
        int              zrun, orun;
        bit              got;

        vecs[0] = '{16'h1234, 1'b0, 4'b0000, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        vecs[1] = '{16'h0050, 1'b1, 4'b0101, {7'h00, 7'h00, 7'h6D, 7'h3F}};
        vecs[2] = '{16'h0000, 1'b1, 4'b1000, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[3] = '{16'h0050, 1'b0, 4'b0000, {7'h3F, 7'h3F, 7'h6D, 7'h3F}};
        vecs[4] = '{16'h1000, 1'b1, 4'b0010, {7'h06, 7'h3F, 7'h3F, 7'h3F}};
        vecs[5] = '{16'hABCD, 1'b0, 4'b1111, {7'h77, 7'h7C, 7'h39, 7'h5E}};
        vecs[6] = '{16'h0E0F, 1'b1, 4'b1100, {7'h00, 7'h79, 7'h3F, 7'h71}};

        rst_n = 1'b0; value_in = '0; value_valid = 1'b0; blank_lz = 1'b0; dp_mask = '0;
        m_pos = 0; m_disp = '0; m_pend = '0; m_pend_full = 0; m_ready = 0; m_last_xfer = 0;

        // Reset held for 3 clocks, then release
        repeat (3) step();
        check("reset_digit_en", digit_en, 4'h0);
        check("reset_segments", segments, 7'h00);
        check("reset_ready", value_ready, 1'b0);
        rst_n = 1'b1;
        step();
        check("ready_after_release", value_ready, 1'b1);

        // Guard: each slot is 2 blank cycles then 6 one-hot cycles
        zrun = 1; orun = 0;
        repeat (2 * FRAME) begin
            step();
            if (digit_en == 4'h0) begin
                if (orun > 0) check("show_len", orun, 6);
                orun = 0; zrun++;
            end else begin
                if (zrun > 0) check("guard_len", zrun, 2);
                zrun = 0; orun++;
            end
        end

        // Table vectors: send, wait for commit, check one full frame
        foreach (vecs[i]) begin
            blank_lz = vecs[i].blank;
            dp_mask  = vecs[i].dpm;
            send(vecs[i].value);
            check("ready_low_after_xfer", value_ready, 1'b0);
            wait_commit();
            capture(FRAME + 1, cs, cdp, cseen);
            for (int d = 0; d < 4; d++) check($sformatf("vec%0d_seg%0d", i, d), cs[d], vecs[i].seg[d]);
            check($sformatf("vec%0d_dp", i), cdp, vecs[i].dpm);
            check($sformatf("vec%0d_seen", i), cseen, 4'hF);
        end

        // Backpressure: B is held until A commits, frames never mix
        blank_lz = 1'b0; dp_mask = '0;
        send(16'hAAAA);
        value_valid = 1'b1; value_in = 16'hBBBB;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = m_last_xfer;
        end
        value_valid = 1'b0;
        check("b_accepted", got, 1);
        capture(FRAME - 2, cs, cdp, cseen);
        for (int d = 0; d < 4; d++) check($sformatf("frame_a_seg%0d", d), cs[d], 7'h77);
        check("frame_a_seen", cseen, 4'hF);
        wait_commit();
        capture(FRAME + 1, cs, cdp, cseen);
        for (int d = 0; d < 4; d++) check($sformatf("frame_b_seg%0d", d), cs[d], 7'h7C);

        // Mid-frame reset during digit 2 with a value pending
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            got = (digit_en == 4'b0001);
        end
        check("reach_digit0", got, 1);
        send(16'h5678);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            got = (digit_en == 4'b0100);
        end
        check("reach_digit2", got, 1);
        check("pending_before_reset", value_ready, 1'b0);
        rst_n = 1'b0;
        repeat (2) step();
        check("midreset_en", digit_en, 4'h0);
        rst_n = 1'b1;
        step();
        check("midreset_ready", value_ready, 1'b1);
        repeat (2) begin
            capture(FRAME + 1, cs, cdp, cseen);
            for (int d = 0; d < 4; d++) check($sformatf("after_reset_seg%0d", d), cs[d], 7'h3F);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            value_valid = ($urandom_range(2) == 0);
            value_in    = 16'($urandom);
            if ($urandom_range(3) == 0) value_in[15:8] = '0;
            dp_mask     = 4'($urandom);
            if (i % 64 == 0) blank_lz = 1'($urandom);
            step();
        end
        value_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
